soma_pipe: RTL and testbench

//  Pipelined, parametrised soma engine: accepts per-neuron integrated input (valid/ready), does

---
 rtl/soma_pipe.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_soma_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soma_pipe.sv
`default_nettype none
// ============================================================================
// Module  : soma_pipe
// Brief   : Three-stage soma engine. Read-modify-write of {refractory, Vm} per
//           neuron, RAW forwarding, clear sweep, and a spike FIFO.
//           Optional macro SOMA_SAT_EN selects saturating Vm arithmetic.
// Revision: 1.0  initial release
// ============================================================================
module soma_pipe #(
  parameter int VW        = 20,
  parameter int NNW       = 12,
  parameter int REFW      = 4,
  parameter int SPK_DEPTH = 8
) (
  input  logic            clk_soma,
  input  logic            rst_n,
  input  logic            cfg_enable,
  input  logic [1:0]      cfg_code,
  input  logic            cfg_reset_mode,
  input  logic [VW-1:0]   cfg_vth,
  input  logic [VW-1:0]   cfg_leak,
  input  logic [REFW-1:0] cfg_refrac,
  input  logic [VW-1:0]   cfg_seed,
  input  logic            cfg_clear,
  output logic            clear_busy,
  input  logic            cfg_vm_we,
  input  logic [NNW-1:0]  cfg_vm_waddr,
  input  logic [VW-1:0]   cfg_vm_wdata,
  input  logic            cfg_vm_re,
  input  logic [NNW-1:0]  cfg_vm_raddr,
  output logic [VW-1:0]   cfg_vm_rdata,
  input  logic            upd_vld,
  output logic            upd_rdy,
  input  logic [NNW-1:0]  upd_addr,
  input  logic [VW-1:0]   upd_val,
  output logic            spk_vld,
  input  logic            spk_rdy,
  output logic [NNW-1:0]  spk_addr
);

  localparam int WW     = VW + REFW;
  localparam int NWORDS = 1 << NNW;
  localparam int PW     = $clog2(SPK_DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [1:0] CODE_IF  = 2'b01;
  localparam logic [1:0] CODE_STO = 2'b10;
  localparam logic [1:0] CODE_OFF = 2'b11;

  localparam logic [CW:0] OCC_MAX = (CW+1)'(SPK_DEPTH - 2);

  function automatic logic [63:0] tap(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // Maximal-length tap sets; widths outside the table fall back to two top taps.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      4:       return tap(4)  | tap(3);
      5:       return tap(5)  | tap(3);
      6:       return tap(6)  | tap(5);
      7:       return tap(7)  | tap(6);
      8:       return tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:       return tap(9)  | tap(5);
      10:      return tap(10) | tap(7);
      11:      return tap(11) | tap(9);
      12:      return tap(12) | tap(6)  | tap(4)  | tap(1);
      13:      return tap(13) | tap(4)  | tap(3)  | tap(1);
      14:      return tap(14) | tap(5)  | tap(3)  | tap(1);
      15:      return tap(15) | tap(14);
      16:      return tap(16) | tap(15) | tap(13) | tap(4);
      17:      return tap(17) | tap(14);
      18:      return tap(18) | tap(11);
      19:      return tap(19) | tap(6)  | tap(2)  | tap(1);
      20:      return tap(20) | tap(17);
      21:      return tap(21) | tap(19);
      22:      return tap(22) | tap(21);
      23:      return tap(23) | tap(18);
      24:      return tap(24) | tap(23) | tap(22) | tap(17);
      25:      return tap(25) | tap(22);
      26:      return tap(26) | tap(6)  | tap(2)  | tap(1);
      27:      return tap(27) | tap(5)  | tap(2)  | tap(1);
      28:      return tap(28) | tap(25);
      29:      return tap(29) | tap(27);
      30:      return tap(30) | tap(6)  | tap(4)  | tap(1);
      31:      return tap(31) | tap(28);
      32:      return tap(32) | tap(22) | tap(2)  | tap(1);
      default: return tap(w)  | tap(w - 1);
    endcase
  endfunction

  localparam logic [VW-1:0] TAPS = VW'(lfsr_taps(VW));

`ifdef SOMA_SAT_EN
  localparam logic [VW-1:0] VMAX = {1'b0, {(VW-1){1'b1}}};
  localparam logic [VW-1:0] VMIN = {1'b1, {(VW-1){1'b0}}};
`endif

  function automatic logic [VW-1:0] add_v(input logic [VW-1:0] a, input logic [VW-1:0] b);
`ifdef SOMA_SAT_EN
    logic [VW:0] s;
    s = {a[VW-1], a} + {b[VW-1], b};
    if (s[VW] != s[VW-1]) return s[VW] ? VMIN : VMAX;
    return s[VW-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [VW-1:0] sub_v(input logic [VW-1:0] a, input logic [VW-1:0] b);
`ifdef SOMA_SAT_EN
    logic [VW:0] s;
    s = {a[VW-1], a} - {b[VW-1], b};
    if (s[VW] != s[VW-1]) return s[VW] ? VMIN : VMAX;
    return s[VW-1:0];
`else
    return a - b;
`endif
  endfunction

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  logic [WW-1:0]  ram [NWORDS];
  logic           ram_we;
  logic [NNW-1:0] ram_waddr;
  logic [WW-1:0]  ram_wdata;

  clr_state_t     clr_state, clr_next;
  logic [NNW-1:0] clr_addr;

  logic           en_q;
  logic [VW-1:0]  lfsr;
  logic           accept;
  logic           cfg_ok;

  logic           s1_vld;
  logic [NNW-1:0] s1_addr;
  logic [VW-1:0]  s1_val;
  logic [VW-1:0]  s1_thr;
  logic [WW-1:0]  s1_rd;

  logic           s2_vld;
  logic           s2_fire;
  logic [NNW-1:0] s2_addr;
  logic [WW-1:0]  s2_word;

  logic [WW-1:0]   old_word;
  logic [VW-1:0]   vm_old, vm_s, vm_new, thr;
  logic [REFW-1:0] ref_old, ref_new;
  logic            fire;

  logic [NNW-1:0] fifo_mem [SPK_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic [CW:0]    occ;
  logic           push, pop;

  // ---------------------------------------------------------------- control
  assign accept     = upd_vld & upd_rdy;
  assign cfg_ok     = ~cfg_enable & ~clear_busy;
  assign clear_busy = (clr_state == CLR_SWEEP);
  assign occ        = {1'b0, count} + (CW+1)'(s1_vld) + (CW+1)'(s2_fire);
  // en_q gates ready so nothing is accepted during reset or the seed-load cycle.
  assign upd_rdy    = en_q & cfg_enable & ~clear_busy & (occ <= OCC_MAX);

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
    end else begin
      clr_state <= clr_next;
      clr_addr  <= (clr_state == CLR_SWEEP) ? clr_addr + 1'b1 : '0;
    end
  end

  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_IDLE:  if (cfg_clear) clr_next = CLR_SWEEP;
      CLR_SWEEP: if (clr_addr == '1) clr_next = CLR_IDLE;
      default:   clr_next = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      lfsr <= VW'(1);
    end else begin
      en_q <= cfg_enable;
      if (cfg_enable & ~en_q)
        lfsr <= (cfg_seed == '0) ? VW'(1) : cfg_seed;
      else if (accept && cfg_code == CODE_STO)
        lfsr <= {lfsr[VW-2:0], ^(lfsr & TAPS)};
    end
  end

  // ------------------------------------------------------------ RAM port mux
  // The sweep owns the write port; a write-back landing mid-sweep is cleared anyway.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (clear_busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
    end else if (s2_vld) begin
      ram_we    = 1'b1;
      ram_waddr = s2_addr;
      ram_wdata = s2_word;
    end else if (cfg_vm_we & ~cfg_enable) begin
      ram_we    = 1'b1;
      ram_waddr = cfg_vm_waddr;
      ram_wdata = {{REFW{1'b0}}, cfg_vm_wdata};
    end
  end

  always_ff @(posedge clk_soma) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) cfg_vm_rdata <= '0;
    else if (cfg_vm_re & cfg_ok) cfg_vm_rdata <= ram[cfg_vm_raddr][VW-1:0];
  end

  // ---------------------------------------------------------------- pipeline
  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_fire <= 1'b0;
    end else begin
      s1_vld  <= accept;
      s2_vld  <= s1_vld;
      s2_fire <= s1_vld & fire;
    end
  end

  // A read colliding with this cycle's write-back must see the new word.
  always_ff @(posedge clk_soma) begin
    if (accept) begin
      s1_addr <= upd_addr;
      s1_val  <= upd_val;
      s1_thr  <= lfsr;
      s1_rd   <= (ram_we && ram_waddr == upd_addr) ? ram_wdata : ram[upd_addr];
    end
    s2_addr <= s1_addr;
    s2_word <= {ref_new, vm_new};
  end

  always_comb begin
    old_word = (s2_vld && s2_addr == s1_addr) ? s2_word : s1_rd;
    vm_old   = old_word[VW-1:0];
    ref_old  = old_word[WW-1:VW];
    vm_s     = (cfg_code == CODE_IF) ? add_v(vm_old, s1_val)
                                     : sub_v(add_v(vm_old, s1_val), cfg_leak);
    thr      = (cfg_code == CODE_STO) ? s1_thr : cfg_vth;
    fire     = 1'b0;
    vm_new   = vm_old;
    ref_new  = ref_old;
    if (cfg_code != CODE_OFF) begin
      if (ref_old != '0) begin
        ref_new = ref_old - REFW'(1);
      end else if ($signed(vm_s) >= $signed(thr)) begin
        fire    = 1'b1;
        vm_new  = cfg_reset_mode ? sub_v(vm_s, cfg_vth) : '0;
        ref_new = cfg_refrac;
      end else begin
        vm_new  = vm_s;
      end
    end
  end

  // ---------------------------------------------------------------- spike FIFO
  assign push     = s2_vld & s2_fire;
  assign pop      = spk_vld & spk_rdy;
  assign spk_vld  = (count != '0);
  assign spk_addr = fifo_mem[rptr];

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPK_DEPTH; i++) fifo_mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= s2_addr;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soma_pipe.sv
`default_nettype none
// Directed bench for soma_pipe: vector table for single updates plus
// sequences for forwarding, clear sweep, stochastic, back-pressure and reset.
module tb_soma_pipe;
  localparam int VW = 20, NNW = 12, REFW = 4, SPK_DEPTH = 8;

  logic            clk_soma = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_enable = 1'b0;
  logic [1:0]      cfg_code = 2'b00;
  logic            cfg_reset_mode = 1'b0;
  logic [VW-1:0]   cfg_vth = '0;
  logic [VW-1:0]   cfg_leak = '0;
  logic [REFW-1:0] cfg_refrac = '0;
  logic [VW-1:0]   cfg_seed = '0;
  logic            cfg_clear = 1'b0;
  logic            clear_busy;
  logic            cfg_vm_we = 1'b0;
  logic [NNW-1:0]  cfg_vm_waddr = '0;
  logic [VW-1:0]   cfg_vm_wdata = '0;
  logic            cfg_vm_re = 1'b0;
  logic [NNW-1:0]  cfg_vm_raddr = '0;
  logic [VW-1:0]   cfg_vm_rdata;
  logic            upd_vld = 1'b0;
  logic            upd_rdy;
  logic [NNW-1:0]  upd_addr = '0;
  logic [VW-1:0]   upd_val = '0;
  logic            spk_vld;
  logic            spk_rdy = 1'b1;
  logic [NNW-1:0]  spk_addr;

  soma_pipe #(.VW(VW), .NNW(NNW), .REFW(REFW), .SPK_DEPTH(SPK_DEPTH)) dut (
    .clk_soma(clk_soma), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_code(cfg_code),
    .cfg_reset_mode(cfg_reset_mode), .cfg_vth(cfg_vth), .cfg_leak(cfg_leak),
    .cfg_refrac(cfg_refrac), .cfg_seed(cfg_seed), .cfg_clear(cfg_clear),
    .clear_busy(clear_busy), .cfg_vm_we(cfg_vm_we), .cfg_vm_waddr(cfg_vm_waddr),
    .cfg_vm_wdata(cfg_vm_wdata), .cfg_vm_re(cfg_vm_re), .cfg_vm_raddr(cfg_vm_raddr),
    .cfg_vm_rdata(cfg_vm_rdata), .upd_vld(upd_vld), .upd_rdy(upd_rdy),
    .upd_addr(upd_addr), .upd_val(upd_val), .spk_vld(spk_vld), .spk_rdy(spk_rdy),
    .spk_addr(spk_addr)
  );

  always #5 clk_soma = ~clk_soma;

  int n_vec = 0;
  int n_err = 0;
  logic [NNW-1:0] spk_q[$];

  always @(negedge clk_soma)
    if (rst_n && spk_vld && spk_rdy) spk_q.push_back(spk_addr);

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_soma);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic go_cfg();
    cfg_enable = 1'b0;
    repeat (4) tick();
  endtask

  task automatic go_run();
    cfg_enable = 1'b1;
    repeat (2) tick();
  endtask

  task automatic cfg_write(input logic [NNW-1:0] a, input logic [VW-1:0] d);
    cfg_vm_we = 1'b1; cfg_vm_waddr = a; cfg_vm_wdata = d;
    tick();
    cfg_vm_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [NNW-1:0] a, output logic [VW-1:0] d);
    cfg_vm_re = 1'b1; cfg_vm_raddr = a;
    tick();
    cfg_vm_re = 1'b0;
    d = cfg_vm_rdata;
  endtask

  task automatic send(input logic [NNW-1:0] a, input logic [VW-1:0] v);
    int n = 0;
    upd_addr = a; upd_val = v; upd_vld = 1'b1;
    while (!upd_rdy && n < 50) begin tick(); n++; end
    if (!upd_rdy) chk("send_rdy_timeout", 32'(upd_rdy), 32'd1);
    tick();
    upd_vld = 1'b0;
  endtask

  typedef struct {
    logic [1:0]      code;
    logic            rmode;
    logic [VW-1:0]   leak;
    logic [REFW-1:0] refrac;
    logic [NNW-1:0]  addr;
    logic [VW-1:0]   val;
    logic            fire;
    logic [VW-1:0]   vm;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [VW-1:0]  rd;
    logic [NNW-1:0] exp_q[$];
    int n, bad, seen_low;
    logic [NNW-1:0] a;

    // code, rmode, leak, refrac, addr, val, fire, vm   (vth = 10 throughout)
    tbl[0]  = '{2'd0, 1'b0, 20'd1, 4'd0, 12'd5, 20'd4,       1'b0, 20'd3};
    tbl[1]  = '{2'd0, 1'b0, 20'd1, 4'd0, 12'd5, 20'd4,       1'b0, 20'd6};
    tbl[2]  = '{2'd0, 1'b0, 20'd1, 4'd0, 12'd5, 20'd4,       1'b0, 20'd9};
    tbl[3]  = '{2'd0, 1'b0, 20'd1, 4'd0, 12'd5, 20'd4,       1'b1, 20'd0};
    tbl[4]  = '{2'd1, 1'b0, 20'd1, 4'd0, 12'd9, 20'd25,      1'b0, 20'd5};
    tbl[5]  = '{2'd1, 1'b0, 20'd1, 4'd0, 12'd9, 20'd5,       1'b1, 20'd0};
    tbl[6]  = '{2'd3, 1'b0, 20'd1, 4'd0, 12'd9, 20'd100,     1'b0, 20'd0};
    tbl[7]  = '{2'd0, 1'b0, 20'd1, 4'd0, 12'd3, 20'hFFFF9,   1'b0, 20'hFFFF8};
    tbl[8]  = '{2'd0, 1'b0, 20'd1, 4'd2, 12'd1, 20'd100,     1'b1, 20'd0};
    tbl[9]  = '{2'd0, 1'b0, 20'd1, 4'd2, 12'd1, 20'd100,     1'b0, 20'd0};
    tbl[10] = '{2'd0, 1'b0, 20'd1, 4'd2, 12'd1, 20'd100,     1'b0, 20'd0};
    tbl[11] = '{2'd0, 1'b0, 20'd1, 4'd2, 12'd1, 20'd100,     1'b1, 20'd0};
    tbl[12] = '{2'd0, 1'b1, 20'd1, 4'd0, 12'd3, 20'd30,      1'b1, 20'd11};

    // Reset values, with cfg_enable high to show ready is still held low
    cfg_enable = 1'b1;
    repeat (3) tick();
    chk("rst_upd_rdy", 32'(upd_rdy), 32'd0);
    chk("rst_spk_vld", 32'(spk_vld), 32'd0);
    chk("rst_spk_addr", 32'(spk_addr), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_rdata", 32'(cfg_vm_rdata), 32'd0);
    cfg_enable = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    // Config write/read, then clear sweep
    cfg_write(12'd0, 20'h12345);
    cfg_write(12'd77, 20'd5);
    cfg_write(12'd4095, 20'd7);
    cfg_read(12'd77, rd);
    chk("cfg_readback", 32'(rd), 32'd5);
    go_run();
    chk("run_upd_rdy", 32'(upd_rdy), 32'd1);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    n = 0; bad = 0;
    while (clear_busy && n < 5000) begin
      if (upd_rdy) bad++;
      if (n == 100) cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0;
      n++;
    end
    chk("clear_len", 32'(n), 32'd4096);
    chk("clear_rdy_low", 32'(bad), 32'd0);
    cfg_vm_we = 1'b1; cfg_vm_waddr = 12'd77; cfg_vm_wdata = 20'd99;
    tick();
    cfg_vm_we = 1'b0;
    go_cfg();
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      cfg_read(NNW'(i), rd);
      if (rd != '0) bad++;
    end
    chk("clear_all_zero", 32'(bad), 32'd0);

    // Table-driven single updates
    cfg_write(12'd9, 20'hFFFEC);
    cfg_vth = 20'd10;
    for (int i = 0; i < 13; i++) begin
      cfg_code = tbl[i].code; cfg_reset_mode = tbl[i].rmode;
      cfg_leak = tbl[i].leak; cfg_refrac = tbl[i].refrac;
      go_run();
      spk_q.delete();
      send(tbl[i].addr, tbl[i].val);
      repeat (6) tick();
      chk($sformatf("v%0d_nspk", i), 32'(spk_q.size()), 32'(tbl[i].fire));
      if (tbl[i].fire && spk_q.size() > 0)
        chk($sformatf("v%0d_spk_addr", i), 32'(spk_q[0]), 32'(tbl[i].addr));
      go_cfg();
      cfg_read(tbl[i].addr, rd);
      chk($sformatf("v%0d_vm", i), 32'(rd), 32'(tbl[i].vm));
    end

    // Back-to-back same neuron (IF ignores leak)
    cfg_code = 2'd1; cfg_leak = 20'd1; cfg_refrac = 4'd0; cfg_reset_mode = 1'b0;
    go_run();
    spk_q.delete();
    upd_vld = 1'b1; upd_addr = 12'd7; upd_val = 20'd6;
    tick(); tick();
    upd_vld = 1'b0;
    repeat (6) tick();
    chk("b2b_nspk", 32'(spk_q.size()), 32'd1);
    if (spk_q.size() > 0) chk("b2b_spk_addr", 32'(spk_q[0]), 32'd7);
    go_cfg();
    cfg_read(12'd7, rd);
    chk("b2b_vm", 32'(rd), 32'd0);

    // A,B,A pattern: third update reads while first is being written back
    go_run();
    spk_q.delete();
    upd_vld = 1'b1;
    upd_addr = 12'd20; upd_val = 20'd3; tick();
    upd_addr = 12'd21; upd_val = 20'd3; tick();
    upd_addr = 12'd20; upd_val = 20'd4; tick();
    upd_vld = 1'b0;
    repeat (6) tick();
    chk("aba_nspk", 32'(spk_q.size()), 32'd0);
    go_cfg();
    cfg_read(12'd20, rd);
    chk("aba_vm20", 32'(rd), 32'd7);
    cfg_read(12'd21, rd);
    chk("aba_vm21", 32'(rd), 32'd3);

    // Stochastic: seed 3, thresholds 3, 6, 12, 24
    cfg_code = 2'd2; cfg_leak = 20'd0; cfg_seed = 20'd3;
    go_run();
    spk_q.delete();
    send(12'd30, 20'd5);
    send(12'd31, 20'd5);
    send(12'd32, 20'd13);
    send(12'd33, 20'd30);
    repeat (6) tick();
    chk("sto_nspk", 32'(spk_q.size()), 32'd3);
    if (spk_q.size() == 3) begin
      chk("sto_spk0", 32'(spk_q[0]), 32'd30);
      chk("sto_spk1", 32'(spk_q[1]), 32'd32);
      chk("sto_spk2", 32'(spk_q[2]), 32'd33);
    end
    go_cfg();
    cfg_read(12'd31, rd);
    chk("sto_vm31", 32'(rd), 32'd5);

    // Overflow at the positive rail
    cfg_write(12'd40, 20'h7FFFB);
    cfg_code = 2'd0; cfg_leak = 20'd1; cfg_vth = 20'h7FFFF;
    go_run();
    spk_q.delete();
    send(12'd40, 20'd10);
    repeat (6) tick();
    chk("sat_nspk", 32'(spk_q.size()), 32'd0);
    go_cfg();
    cfg_read(12'd40, rd);
`ifdef SOMA_SAT_EN
    chk("sat_vm", 32'(rd), 32'h7FFFE);
`else
    chk("wrap_vm", 32'(rd), 32'h80004);
`endif

    // Back-pressure: consumer stalled, every update fires
    cfg_code = 2'd1; cfg_vth = 20'd10;
    go_run();
    spk_rdy = 1'b0;
    spk_q.delete();
    seen_low = 0;
    a = 12'd100;
    upd_vld = 1'b1; upd_val = 20'd50;
    for (int c = 0; c < 20; c++) begin
      upd_addr = a;
      if (upd_rdy) begin exp_q.push_back(a); a++; end
      else seen_low = 1;
      tick();
    end
    upd_vld = 1'b0;
    repeat (4) tick();
    chk("bp_rdy_dropped", 32'(seen_low), 32'd1);
    chk("bp_spk_vld", 32'(spk_vld), 32'd1);
    chk("bp_enough_held", 32'(exp_q.size() >= SPK_DEPTH - 2 && exp_q.size() <= SPK_DEPTH), 32'd1);
    spk_rdy = 1'b1;
    repeat (20) tick();
    chk("bp_drained", 32'(spk_q.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < spk_q.size(); i++)
      if (spk_q[i] != exp_q[i]) bad++;
    chk("bp_order", 32'(bad), 32'd0);
    chk("bp_rdy_back", 32'(upd_rdy), 32'd1);

    // Reset in the middle of activity
    spk_rdy = 1'b0;
    send(12'd200, 20'd50);
    send(12'd201, 20'd50);
    repeat (4) tick();
    chk("mid_spk_vld", 32'(spk_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_spk_vld", 32'(spk_vld), 32'd0);
    chk("mid_rst_upd_rdy", 32'(upd_rdy), 32'd0);
    tick();
    rst_n = 1'b1;
    spk_rdy = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
